seg_display_driver: RTL and testbench
=====================================

# seg_display_driver

- Display end of the LED counter path: accepts a 7-bit binary value (0–99 from the up-counter) and drives a 2-digit multiplexed 7-segment display.
- Converts binary to BCD with a sequential shift-add-3 (double-dabble) FSM, only when the input changes.
- Time-multiplexes the two digit enables at a divided scan rate.
- Sits between the counter and the board's segment/anode pins.

## Interface
- `SCAN_DIV`, default 100000: clk cycles per digit slot; must be ≥ 2. At 100 MHz this gives 1 kHz per digit.
- `BLANK_LZ`, default 1: 1 blanks the tens digit when it is 0 and the value is valid.
- `clk` input 1: system clock, the single clock domain.
- `rst_n` input 1: asynchronous, active-low reset.
- `num` input 7: binary value to display; 0–99 valid, 100–127 out of range.
- `seg` output 8: segments {dp,g,f,e,d,c,b,a}, active-high; dp is always 0.
- `an` output 2: digit enables, active-high; an[0] = ones, an[1] = tens; one-hot or 00.
- `busy` output 1: high while a conversion is in progress.

## Operation
- Reset values:
  - seg=8'h00, an=2'b00, busy=0.
  - last_num=0; shown digits tens=BLANK (if BLANK_LZ) else '0', ones='0'.
  - FSM=IDLE; scan counter=0; digit select=0; scan_active=0.
- FSM states: IDLE → CONV → LOAD → IDLE.
- IDLE:
  - If num != last_num, capture num into the shift register and last_num.
  - Clear the BCD accumulator, set bit counter=0, go to CONV.
  - Otherwise stay in IDLE.
- CONV, 7 cycles (bit counter 0..6):
  - For each BCD nibble ≥ 5, add 3.
  - Then shift {tens,ones,shift} left 1.
  - After the 7th shift, go to LOAD.
- LOAD, 1 cycle:
  - Captured value ≤ 99: tens/ones display codes take the BCD result. If BLANK_LZ and tens==0, the tens code is BLANK.
  - Captured value ≥ 100: both codes are DASH (segment g only, 8'h40).
  - Return to IDLE.
- busy is 1 in CONV and LOAD, 0 in IDLE.
- num changes during CONV/LOAD are not sampled. On return to IDLE the current num is compared to last_num, so the final value is always converted. Intermediate values may be skipped.
- Scan counter:
  - Counts 0..SCAN_DIV-1 and wraps.
  - At terminal count: set scan_active=1 and toggle the digit select.
  - The select order is ones first, then tens, alternating.
- Outputs, registered:
  - When scan_active=1: an = select ? 2'b10 : 2'b01; seg = the code of the selected digit.
  - When scan_active=0: an=2'b00, seg=8'h00.
- Segment codes, active-high:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - BLANK=00, DASH=40.

## Timing
- num change at edge N is detected in IDLE at edge N+1.
- CONV runs edges N+2..N+8. LOAD at N+9 updates the digit codes.
- The new code appears on seg at the next registered output update for that digit.
- Worst-case conversion latency is 9 cycles with the FSM idle, or up to 17 if a conversion was already running.
- The first digit enable occurs SCAN_DIV cycles after reset deassertion: an=01, showing the ones digit.
- Each enable lasts exactly SCAN_DIV cycles. an is never 2'b11. There is no dead time between digits.
- Reset asserted mid-conversion:
  - All state returns to reset values immediately, without waiting for a clock.
  - The partial result is discarded and outputs blank.
- Scan timing is independent of the FSM. A LOAD in the middle of a slot changes seg within that slot on the next cycle.

## Structure
- Package `seg_pkg` holds:
  - Segment code constants SEG_0..SEG_9, SEG_BLANK, SEG_DASH.
  - The FSM state typedef (IDLE, CONV, LOAD).
  - The function mapping a 4-bit BCD value to a segment code.
- Sub-module `bin2bcd_seq` contains the FSM, the shift/BCD registers, last_num and busy. Its outputs are tens, ones, out_of_range and a 1-cycle `done` pulse.
- The top level holds the scan divider, the digit select, the code registers and the output registers.

## Test plan
All directed scenarios use SCAN_DIV=4.
- **Reset:** hold rst_n=0 for 10 cycles with num=0, then release.
  - seg=00, an=00 for 4 cycles.
  - Then an=01 with seg=3F, then an=10 with seg=00 (blanked tens), alternating every 4 cycles.
- **Convert 57:** set num=57 from 0.
  - busy is high for exactly 8 cycles.
  - Afterwards the ones slot shows 07 and the tens slot shows 6D.
- **Wrap 99→0:** drive num 98, 99, 0, each held 20 cycles.
  - Tens/ones show 6F/7F, then 6F/6F, then blank/3F.
  - With BLANK_LZ=0, the last case shows 3F/3F.
- **Out of range:** num=100, then num=127.
  - Both slots show 40; an never equals 11.
- **Change mid-conversion:** num=12, then num=34 two cycles later.
  - Two busy bursts occur.
  - The final display is 4F (tens) / 66 (ones); 12 may or may not appear.
- **Async reset mid-conversion:** assert rst_n=0 on the 3rd CONV cycle of num=88.
  - busy, seg and an go to 0 before the next clk edge.
  - After release, the display shows 0 and the next IDLE detects 88 and converts it.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants, FSM state encoding and BCD-to-segment decode for the
// two-digit 7-segment display driver.
package seg_pkg;

   // Segment bit order {dp,g,f,e,d,c,b,a}, active-high
   localparam logic [7:0] SEG_0     = 8'h3F;
   localparam logic [7:0] SEG_1     = 8'h06;
   localparam logic [7:0] SEG_2     = 8'h5B;
   localparam logic [7:0] SEG_3     = 8'h4F;
   localparam logic [7:0] SEG_4     = 8'h66;
   localparam logic [7:0] SEG_5     = 8'h6D;
   localparam logic [7:0] SEG_6     = 8'h7D;
   localparam logic [7:0] SEG_7     = 8'h07;
   localparam logic [7:0] SEG_8     = 8'h7F;
   localparam logic [7:0] SEG_9     = 8'h6F;
   localparam logic [7:0] SEG_BLANK = 8'h00;
   localparam logic [7:0] SEG_DASH  = 8'h40;

   localparam int unsigned NUM_W = 7;
   localparam int unsigned BCD_W = 4;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_CONV = 2'd1;
   localparam state_t ST_LOAD = 2'd2;

   function automatic logic [7:0] bcd_to_seg(input logic [BCD_W-1:0] d);
      logic [7:0] s;
      case (d)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/seg_display_driver_bin2bcd_seq.sv
// Sequential double-dabble converter: 7-bit binary to two BCD digits,
// started only when the input differs from the last converted value.
module bin2bcd_seq
   import seg_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NUM_W-1:0] num_i,
   output logic [BCD_W-1:0] tens_o,
   output logic [BCD_W-1:0] ones_o,
   output logic             out_of_range_o,
   output logic             done_o,
   output logic             busy_o
);

   state_t           state_q, state_d;
   logic [NUM_W-1:0] shift_q, shift_d;
   logic [NUM_W-1:0] last_q, last_d;
   logic [BCD_W-1:0] tens_q, tens_d;
   logic [BCD_W-1:0] ones_q, ones_d;
   logic [2:0]       cnt_q, cnt_d;
   logic             oor_q, oor_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [BCD_W-1:0] tens_adj, ones_adj;
   logic [2*BCD_W+NUM_W-1:0] cat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         shift_q <= '0;
         last_q  <= '0;
         tens_q  <= '0;
         ones_q  <= '0;
         cnt_q   <= '0;
         oor_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         last_q  <= last_d;
         tens_q  <= tens_d;
         ones_q  <= ones_d;
         cnt_q   <= cnt_d;
         oor_q   <= oor_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      last_d  = last_q;
      tens_d  = tens_q;
      ones_d  = ones_q;
      cnt_d   = cnt_q;
      oor_d   = oor_q;

      // Add-3 correction then shift one bit of binary into the BCD digits
      tens_adj = (tens_q >= 4'd5) ? tens_q + 4'd3 : tens_q;
      ones_adj = (ones_q >= 4'd5) ? ones_q + 4'd3 : ones_q;
      cat      = {tens_adj, ones_adj, shift_q} << 1;

      case (state_q)
         ST_IDLE: begin
            if (num_i != last_q) begin
               shift_d = num_i;
               last_d  = num_i;
               oor_d   = (num_i >= 7'd100);
               tens_d  = '0;
               ones_d  = '0;
               cnt_d   = '0;
               state_d = ST_CONV;
            end
         end
         ST_CONV: begin
            {tens_d, ones_d, shift_d} = cat;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd6) state_d = ST_LOAD;
         end
         ST_LOAD: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_LOAD);
   end

   assign tens_o         = tens_q;
   assign ones_o         = ones_q;
   assign out_of_range_o = oor_q;
   assign done_o         = done_q;
   assign busy_o         = busy_q;

endmodule

// File: rtl/seg_display_driver.sv
// Two-digit multiplexed 7-segment driver: converts the counter value to BCD
// and scans the ones/tens digits at SCAN_DIV clocks per slot.
module seg_display_driver
   import seg_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 100000,
   parameter bit          BLANK_LZ = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NUM_W-1:0] num,
   output logic [7:0]       seg,
   output logic [1:0]       an,
   output logic             busy
);

   localparam int unsigned CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

   logic [BCD_W-1:0] bcd_tens, bcd_ones;
   logic             bcd_oor, bcd_done;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sel_q, sel_d;
   logic             act_q, act_d;
   logic [7:0]       tens_code_q, tens_code_d;
   logic [7:0]       ones_code_q, ones_code_d;
   logic [7:0]       seg_q, seg_d;
   logic [1:0]       an_q, an_d;
   logic             term;
   logic             show_tens;

   bin2bcd_seq u_bin2bcd (
      .clk            (clk),
      .rst_n          (rst_n),
      .num_i          (num),
      .tens_o         (bcd_tens),
      .ones_o         (bcd_ones),
      .out_of_range_o (bcd_oor),
      .done_o         (bcd_done),
      .busy_o         (busy)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         sel_q       <= 1'b0;
         act_q       <= 1'b0;
         tens_code_q <= BLANK_LZ ? SEG_BLANK : SEG_0;
         ones_code_q <= SEG_0;
         seg_q       <= 8'h00;
         an_q        <= 2'b00;
      end else begin
         cnt_q       <= cnt_d;
         sel_q       <= sel_d;
         act_q       <= act_d;
         tens_code_q <= tens_code_d;
         ones_code_q <= ones_code_d;
         seg_q       <= seg_d;
         an_q        <= an_d;
      end
   end

   always_comb begin
      term  = (cnt_q == CNT_W'(SCAN_DIV - 1));
      cnt_d = term ? '0 : cnt_q + CNT_W'(1);
      sel_d = term ? ~sel_q : sel_q;
      act_d = act_q | term;

      tens_code_d = tens_code_q;
      ones_code_d = ones_code_q;
      if (bcd_done) begin
         if (bcd_oor) begin
            tens_code_d = SEG_DASH;
            ones_code_d = SEG_DASH;
         end else begin
            ones_code_d = bcd_to_seg(bcd_ones);
            tens_code_d = (BLANK_LZ && bcd_tens == 4'd0) ? SEG_BLANK : bcd_to_seg(bcd_tens);
         end
      end

      // sel_q names the digit for the upcoming slot; mid-slot the current one is its complement
      show_tens = term ? sel_q : ~sel_q;
      an_d  = 2'b00;
      seg_d = 8'h00;
      if (act_d) begin
         an_d  = show_tens ? 2'b10 : 2'b01;
         seg_d = show_tens ? tens_code_q : ones_code_q;
      end
   end

   assign seg = seg_q;
   assign an  = an_q;

endmodule

// File: tb/tb_seg_display_driver.sv
// Directed bench for seg_display_driver with SCAN_DIV=4; a second instance
// with leading-zero blanking disabled shares all inputs.
module tb_seg_display_driver;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] num;
   logic [7:0] seg, seg_nb;
   logic [1:0] an, an_nb;
   logic       busy, busy_nb;
   logic       saw11 = 1'b0;

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   seg_display_driver #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .num(num), .seg(seg), .an(an), .busy(busy)
   );

   seg_display_driver #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_nb (
      .clk(clk), .rst_n(rst_n), .num(num), .seg(seg_nb), .an(an_nb), .busy(busy_nb)
   );

   always @(negedge clk) begin
      if (an == 2'b11 || an_nb == 2'b11) saw11 = 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Wait for each slot in turn and check both instances' segment codes
   task automatic show(input string tag, input logic [7:0] et, input logic [7:0] eo,
                       input logic [7:0] et_nb, input logic [7:0] eo_nb);
      for (int i = 0; i < 20 && an !== 2'b01; i++) @(negedge clk);
      chk({tag, "_an_ones"}, an, 2'b01);
      chk({tag, "_ones"}, seg, eo);
      chk({tag, "_ones_nb"}, seg_nb, eo_nb);
      for (int i = 0; i < 20 && an !== 2'b10; i++) @(negedge clk);
      chk({tag, "_an_tens"}, an, 2'b10);
      chk({tag, "_tens"}, seg, et);
      chk({tag, "_tens_nb"}, seg_nb, et_nb);
   endtask

   task automatic set_num(input logic [6:0] v, input int hold);
      num = v;
      repeat (hold) @(negedge clk);
   endtask

   initial begin
      int high_cnt;
      int bursts;
      logic prev_busy;
      logic [1:0] exp_an;
      logic [7:0] exp_seg, exp_seg_nb;

      rst_n = 1'b0;
      num   = 7'd0;
      repeat (10) @(negedge clk);
      rst_n = 1'b1;

      // Reset and scan start: blank for 4 cycles, then ones/tens alternating
      for (int e = 0; e < 16; e++) begin
         if (e > 0) @(negedge clk);
         if (e < 4) begin
            exp_an = 2'b00; exp_seg = 8'h00; exp_seg_nb = 8'h00;
         end else if ((((e - 4) / 4) % 2) == 0) begin
            exp_an = 2'b01; exp_seg = 8'h3F; exp_seg_nb = 8'h3F;
         end else begin
            exp_an = 2'b10; exp_seg = 8'h00; exp_seg_nb = 8'h3F;
         end
         chk($sformatf("rst_an_e%0d", e), an, exp_an);
         chk($sformatf("rst_seg_e%0d", e), seg, exp_seg);
         chk($sformatf("rst_seg_nb_e%0d", e), seg_nb, exp_seg_nb);
         chk($sformatf("rst_busy_e%0d", e), busy, 1'b0);
      end

      // Convert 57: busy width and digits
      num = 7'd57;
      high_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy) high_cnt++;
      end
      chk("busy57_len", high_cnt, 8);
      show("v57", 8'h6D, 8'h07, 8'h6D, 8'h07);

      // 98 -> 99 -> 0 wrap
      set_num(7'd98, 20);
      show("v98", 8'h6F, 8'h7F, 8'h6F, 8'h7F);
      set_num(7'd99, 20);
      show("v99", 8'h6F, 8'h6F, 8'h6F, 8'h6F);
      set_num(7'd0, 20);
      show("v00", 8'h00, 8'h3F, 8'h3F, 8'h3F);

      // Out of range
      set_num(7'd100, 20);
      show("v100", 8'h40, 8'h40, 8'h40, 8'h40);
      set_num(7'd127, 20);
      show("v127", 8'h40, 8'h40, 8'h40, 8'h40);

      // Change mid-conversion: two busy bursts, last value wins
      num = 7'd12;
      bursts = 0;
      prev_busy = busy;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i == 1) num = 7'd34;
         if (busy && !prev_busy) bursts++;
         prev_busy = busy;
      end
      chk("mid_bursts", bursts, 2);
      show("v34", 8'h4F, 8'h66, 8'h4F, 8'h66);

      // Async reset on the 3rd CONV cycle of 88
      num = 7'd88;
      repeat (3) @(negedge clk);
      chk("busy_pre_rst", busy, 1'b1);
      chk("an_pre_rst_active", (an != 2'b00), 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_busy", busy, 1'b0);
      chk("async_seg", seg, 8'h00);
      chk("async_an", an, 2'b00);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("busy_after_rst", busy, 1'b1);
      show("rst_zero", 8'h00, 8'h3F, 8'h3F, 8'h3F);
      repeat (12) @(negedge clk);
      show("v88", 8'h7F, 8'h7F, 8'h7F, 8'h7F);

      chk("an_never_11", saw11, 1'b0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
